// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares a single-ported memory between instruction fetch (IFU) and
//   load/store (LSU). One transaction is outstanding at a time:
//   IDLE (arbitrate/accept) -> REQ (present to memory) -> WAIT (await response).
//   LSU wins contested arbitration until the starvation counter reaches
//   STARVE_MAX. After that, IFU wins once and the counter clears.
//   A flush drops the response of an in-flight fetch.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   ifu_req_*                     fetch request (valid/ready/addr)
//   ifu_resp_valid/data           fetch response pulse and data
//   lsu_req_*                     data request (valid/ready/addr/wen/wdata/wmask)
//   lsu_resp_valid/data           load data or store-ack pulse
//   flush                         masks fetch requests and drops fetch responses
//   mem_req_*                     registered request to memory (valid/ready handshake)
//   mem_resp_valid/data           memory response
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_resp_data,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_resp_data,
  input  logic                flush,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t              r_state;
  state_t              w_state_nx;
  owner_t              r_owner;
  logic                r_drop;
  logic [3:0]          r_starve;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wmask;

  logic w_ifu_cand;
  logic w_lsu_win;
  logic w_ifu_win;
  logic w_suppress;

  // Flush removes the fetch request from arbitration for this cycle.
  assign w_ifu_cand = ifu_req_valid && !flush;
  assign w_lsu_win  = lsu_req_valid && (!w_ifu_cand || (r_starve < STARVE_LIM));
  assign w_ifu_win  = w_ifu_cand && !w_lsu_win;

  // A flush arriving together with the fetch response suppresses it immediately.
  assign w_suppress = r_drop || (flush && (r_owner == OWN_IFU));

  assign ifu_resp_data = mem_resp_data;
  assign lsu_resp_data = mem_resp_data;
  assign mem_req_addr  = r_addr;
  assign mem_req_wen   = r_wen;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wmask = r_wmask;

  always_comb begin
    w_state_nx     = r_state;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          ifu_req_ready = w_ifu_win;
          lsu_req_ready = w_lsu_win;
          if (w_ifu_win || w_lsu_win) w_state_nx = S_REQ;
        end
        S_REQ: begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) w_state_nx = S_WAIT;
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            w_state_nx = S_IDLE;
            if (!w_suppress) begin
              if (r_owner == OWN_IFU) ifu_resp_valid = 1'b1;
              else                    lsu_resp_valid = 1'b1;
            end
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_owner  <= OWN_IFU;
      r_drop   <= 1'b0;
      r_starve <= '0;
      r_addr   <= '0;
      r_wen    <= 1'b0;
      r_wdata  <= '0;
      r_wmask  <= '0;
    end else begin
      r_state <= w_state_nx;

      if (r_state == S_IDLE) begin
        if (w_lsu_win) begin
          r_owner <= OWN_LSU;
          r_addr  <= lsu_req_addr;
          r_wen   <= lsu_req_wen;
          r_wdata <= lsu_req_wdata;
          r_wmask <= lsu_req_wmask;
          if (w_ifu_cand && (r_starve < STARVE_LIM)) r_starve <= r_starve + 4'd1;
        end else if (w_ifu_win) begin
          r_owner  <= OWN_IFU;
          r_addr   <= ifu_req_addr;
          r_wen    <= 1'b0;
          r_wdata  <= '0;
          r_wmask  <= '0;
          r_starve <= '0;
        end
      end

      if ((r_state == S_WAIT) && mem_resp_valid)
        r_drop <= 1'b0;
      else if (((r_state == S_REQ) || (r_state == S_WAIT)) && flush && (r_owner == OWN_IFU))
        r_drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_resp_data;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_resp_data;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  int unsigned total = 0;
  int unsigned bad   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Grant sequence expected with both requesters continuously valid (STARVE_MAX=4).
  logic       exp_lsu_g [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [3:0] exp_cnt   [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_req_addr = '0;
    lsu_req_valid = 1'b1; lsu_req_addr = '0; lsu_req_wen = 1'b0;
    lsu_req_wdata = '0; lsu_req_wmask = '0;
    flush = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;

    // ---- reset state (requests held valid: readies must still be 0)
    cyc(); cyc();
    #1;
    chk("rst_ifu_ready", 64'(ifu_req_ready), 64'd0);
    chk("rst_lsu_ready", 64'(lsu_req_ready), 64'd0);
    chk("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_mem_addr",  64'(mem_req_addr),  64'd0);
    chk("rst_mem_wmask", 64'(mem_req_wmask), 64'd0);
    chk("rst_counter",   64'(dut.r_starve),  64'd0);
    cyc();
    rst = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

    // ---- IFU-only fetch: handshake N, mem_req_valid N+1, response N+2
    cyc();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000; mem_req_ready = 1'b1;
    #1;
    chk("ifu_only_ready",    64'(ifu_req_ready), 64'd1);
    chk("ifu_only_lsu_rdy",  64'(lsu_req_ready), 64'd0);
    cyc();
    ifu_req_valid = 1'b0;
    #1;
    chk("ifu_only_memvalid", 64'(mem_req_valid), 64'd1);
    chk("ifu_only_addr",     64'(mem_req_addr),  64'h8000_0000);
    chk("ifu_only_wen",      64'(mem_req_wen),   64'd0);
    cyc();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0413;
    #1;
    chk("ifu_only_resp",     64'(ifu_resp_valid), 64'd1);
    chk("ifu_only_data",     64'(ifu_resp_data),  64'h413);
    chk("ifu_only_lsu_resp", 64'(lsu_resp_valid), 64'd0);
    chk("ifu_only_wait_mv",  64'(mem_req_valid),  64'd0);
    cyc();
    mem_resp_valid = 1'b0;
    #1;
    chk("ifu_only_pulse_end", 64'(ifu_resp_valid), 64'd0);

    // ---- simultaneous requests, counter=0: LSU first, then IFU
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0004;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_0100; lsu_req_wen = 1'b0;
    #1;
    chk("both_lsu_ready", 64'(lsu_req_ready), 64'd1);
    chk("both_ifu_ready", 64'(ifu_req_ready), 64'd0);
    cyc();
    lsu_req_valid = 1'b0;
    #1;
    chk("both_req_no_ready", 64'(ifu_req_ready), 64'd0);
    chk("both_req_addr",     64'(mem_req_addr),  64'h100);
    cyc();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0055;
    #1;
    chk("both_lsu_resp",  64'(lsu_resp_valid), 64'd1);
    chk("both_no_ifu_rs", 64'(ifu_resp_valid), 64'd0);
    cyc();
    mem_resp_valid = 1'b0;
    #1;
    chk("both_ifu_next",  64'(ifu_req_ready), 64'd1);
    chk("both_cnt_pre",   64'(dut.r_starve),  64'd1);
    cyc();
    ifu_req_valid = 1'b0;
    #1;
    chk("both_cnt_post",  64'(dut.r_starve),  64'd0);
    cyc();
    mem_resp_valid = 1'b1;
    cyc();
    mem_resp_valid = 1'b0;

    // ---- starvation: both continuously valid
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("starve_cnt_%0d", k), 64'(dut.r_starve),  64'(exp_cnt[k]));
      chk($sformatf("starve_lsu_%0d", k), 64'(lsu_req_ready), 64'(exp_lsu_g[k]));
      chk($sformatf("starve_ifu_%0d", k), 64'(ifu_req_ready), 64'(!exp_lsu_g[k]));
      cyc();
      cyc();
      mem_resp_valid = 1'b1;
      #1;
      chk($sformatf("starve_resp_%0d", k), 64'(lsu_resp_valid), 64'(exp_lsu_g[k]));
      cyc();
      mem_resp_valid = 1'b0;
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

    // ---- flush masks IFU from arbitration
    ifu_req_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flush_mask_ready", 64'(ifu_req_ready), 64'd0);
    cyc();
    ifu_req_valid = 1'b0; flush = 1'b0;

    // ---- store with stalled memory: fields stable for 3 cycles
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1'b1;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'hF; mem_req_ready = 1'b0;
    #1;
    chk("store_ready", 64'(lsu_req_ready), 64'd1);
    cyc();
    lsu_req_valid = 1'b0; lsu_req_addr = 32'h1234_5678; lsu_req_wen = 1'b0;
    lsu_req_wdata = 32'h0; lsu_req_wmask = 4'h0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("store_valid_%0d", k), 64'(mem_req_valid), 64'd1);
      chk($sformatf("store_addr_%0d", k),  64'(mem_req_addr),  64'h8000_1000);
      chk($sformatf("store_wen_%0d", k),   64'(mem_req_wen),   64'd1);
      chk($sformatf("store_wdata_%0d", k), 64'(mem_req_wdata), 64'hDEAD_BEEF);
      chk($sformatf("store_wmask_%0d", k), 64'(mem_req_wmask), 64'hF);
      cyc();
    end
    mem_req_ready = 1'b1;
    #1;
    chk("store_still_valid", 64'(mem_req_valid), 64'd1);
    cyc();
    mem_resp_valid = 1'b1;
    #1;
    chk("store_ack", 64'(lsu_resp_valid), 64'd1);
    cyc();
    mem_resp_valid = 1'b0;

    // ---- flush during fetch: response dropped, next fetch normal
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0020;
    cyc();
    ifu_req_valid = 1'b0;
    cyc();
    flush = 1'b1;
    #1;
    chk("flush_wait_noresp", 64'(ifu_resp_valid), 64'd0);
    cyc();
    flush = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hAAAA_0001;
    #1;
    chk("flush_dropped", 64'(ifu_resp_valid), 64'd0);
    cyc();
    mem_resp_valid = 1'b0;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0010;
    #1;
    chk("flush_next_ready", 64'(ifu_req_ready), 64'd1);
    cyc();
    ifu_req_valid = 1'b0;
    #1;
    chk("flush_next_addr", 64'(mem_req_addr), 64'h8000_0010);
    cyc();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0013;
    #1;
    chk("flush_next_resp", 64'(ifu_resp_valid), 64'd1);
    chk("flush_next_data", 64'(ifu_resp_data),  64'h13);
    cyc();
    mem_resp_valid = 1'b0;

    // ---- flush coinciding with the fetch response
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0030;
    cyc();
    ifu_req_valid = 1'b0;
    cyc();
    flush = 1'b1; mem_resp_valid = 1'b1;
    #1;
    chk("flush_coincide", 64'(ifu_resp_valid), 64'd0);
    cyc();
    flush = 1'b0; mem_resp_valid = 1'b0;

    // ---- flush while LSU owns the transaction has no effect
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_0200; lsu_req_wen = 1'b0;
    cyc();
    lsu_req_valid = 1'b0; flush = 1'b1;
    cyc();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0077;
    #1;
    chk("flush_lsu_resp", 64'(lsu_resp_valid), 64'd1);
    chk("flush_lsu_data", 64'(lsu_resp_data),  64'h77);
    cyc();
    flush = 1'b0; mem_resp_valid = 1'b0;

    // ---- reset in WAIT: stray response ignored, counter cleared
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0040;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_0300;
    cyc();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    #1;
    chk("rstw_cnt_set", 64'(dut.r_starve), 64'd1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; mem_resp_valid = 1'b1;
    #1;
    chk("rstw_no_lsu_resp", 64'(lsu_resp_valid), 64'd0);
    chk("rstw_no_ifu_resp", 64'(ifu_resp_valid), 64'd0);
    chk("rstw_no_memvalid", 64'(mem_req_valid),  64'd0);
    chk("rstw_counter",     64'(dut.r_starve),   64'd0);
    lsu_req_valid = 1'b1;
    #1;
    chk("rstw_idle_ready",  64'(lsu_req_ready),  64'd1);
    cyc();
    mem_resp_valid = 1'b0; lsu_req_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported main memory between the instruction-fetch requester (IFU) and the load/store requester (LSU).
- Sits between the fetch/memory stages and the memory model or bus.
- Allows one outstanding transaction at a time and uses valid/ready request handshakes.
- LSU has priority by default, bounded by a starvation counter that guarantees IFU progress. A flush input discards an in-flight fetch response.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_MAX, 4, consecutive contested LSU grants after which IFU wins the next arbitration (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  reset
ifu_req_valid  in  1  fetch request
ifu_req_ready  out  1  fetch request accepted
ifu_req_addr  in  ADDR_W  fetch address
ifu_resp_valid  out  1  fetch data valid (1-cycle pulse)
ifu_resp_data  out  DATA_W  fetched instruction
lsu_req_valid  in  1  data request
lsu_req_ready  out  1  data request accepted
lsu_req_addr  in  ADDR_W  data address
lsu_req_wen  in  1  1=store, 0=load
lsu_req_wdata  in  DATA_W  store data
lsu_req_wmask  in  DATA_W/8  byte strobes
lsu_resp_valid  out  1  load data / store ack (1-cycle pulse)
lsu_resp_data  out  DATA_W  load data (don't-care for store)
flush  in  1  system flush; drop pending IFU transaction response
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  registered address
mem_req_wen  out  1  registered write enable
mem_req_wdata  out  DATA_W  registered write data
mem_req_wmask  out  DATA_W/8  registered strobes
mem_resp_valid  in  1  memory response (read data or write ack)
mem_resp_data  in  DATA_W  read data

Behaviour:
- Reset: rst is synchronous, active-high; clk is the clock.
  - Reset values: state=IDLE; owner=IFU; drop=0; starvation counter=0.
  - All valid/ready outputs are 0.
  - mem_req_addr, mem_req_wen, mem_req_wdata and mem_req_wmask reset to 0.
  - ifu_resp_data and lsu_resp_data are combinational pass-throughs of mem_resp_data.
- FSM: IDLE -> REQ -> WAIT -> IDLE. There are no other states.
- IDLE:
  - Arbitration is combinational. ifu_req_ready and lsu_req_ready are asserted only in IDLE, and never both in the same cycle.
  - Winner rule:
    - If only one requester is valid, it wins.
    - If both are valid, LSU wins unless the counter is ≥ STARVE_MAX, in which case IFU wins.
    - flush=1 masks ifu_req_valid from arbitration in that cycle.
  - On handshake, capture addr/wen/wdata/wmask into the mem_req_* registers and record the owner.
  - An IFU capture forces wen=0 and wmask=0.
  - Next state is REQ.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on an LSU grant while ifu_req_valid && !flush.
  - Clears on an IFU grant.
  - Unchanged otherwise.
- REQ:
  - mem_req_valid=1. Registered fields are held stable until mem_req_ready.
  - On mem_req_ready, go to WAIT.
  - A request must not be retracted once presented.
- WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid, pulse <owner>_resp_valid in the same cycle (combinational), unless drop=1 (then no pulse).
  - Next state is IDLE, and drop clears.
- Flush:
  - flush=1 in REQ or WAIT with owner=IFU sets drop=1. The transaction still completes on the memory side.
  - Flush with owner=LSU has no effect.
  - If flush coincides with mem_resp_valid in WAIT and owner=IFU, the response is suppressed in that cycle.
- mem_resp_valid outside WAIT is ignored.
- Latency:
  - Handshake in cycle N -> mem_req_valid in N+1.
  - With mem_req_ready=1 in N+1, the earliest response is N+2.
  - The next acceptance is possible the cycle after the response.
  - Minimum 3 cycles per transaction.
- rst mid-transaction aborts to IDLE immediately. Any later stray mem_resp_valid is ignored.

Test Plan:
- IFU-only traffic:
  - Stimulus: ifu addr 0x80000000, mem_req_ready=1, resp 1 cycle later with data 0x00000413.
  - Required response: ifu_resp_valid pulses at N+2 with 0x00000413, and mem_req_wen=0.
- Simultaneous requests:
  - Stimulus: both valid with counter=0.
  - Required response: LSU granted first. IFU is granted at the next IDLE if LSU drops valid.
- Starvation, STARVE_MAX=4:
  - Stimulus: both continuously valid.
  - Required response: grant sequence LSU,LSU,LSU,LSU,IFU,LSU…; counter reads 4 before the IFU grant and 0 after.
- Store:
  - Stimulus: lsu wen=1, addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF.
  - Required response: mem_req_* show those values while valid. mem_req_ready held 0 for 3 cycles keeps the fields stable. The write ack yields lsu_resp_valid=1.
- Flush during fetch:
  - Stimulus: IFU request granted, flush asserted in WAIT before the response.
  - Required response: no ifu_resp_valid, FSM returns to IDLE. A new IFU request to 0x80000010 is accepted next and its response is delivered normally.
- Reset in WAIT:
  - Stimulus: rst=1 for 1 cycle, then mem_resp_valid=1.
  - Required response: no resp_valid pulse, state=IDLE, counter=0.
